ltz_sweep_checker: RTL
======================

LTZ_SWEEP_CHECKER -- requirements
Module: ltz_sweep_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width driven to the less-than-zero unit under check.
REQ-002 SHALL have parameter CNT_W, default 8: width of the error counter.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port START, input, 1: begin a sweep; sampled only in IDLE.
REQ-006 SHALL have port ABORT, input, 1: synchronous sweep cancel.
REQ-007 SHALL have port FIRST, input, WIDTH: first operand of the sweep; latched on an accepted START.
REQ-008 SHALL have port LAST, input, WIDTH: last operand of the sweep; latched on an accepted START.
REQ-009 SHALL have port SETTLE, input, 4: wait cycles between driving an operand and sampling the result; latched on an accepted START.
REQ-010 SHALL have port A_OUT, output, WIDTH: operand driven to the unit under check.
REQ-011 SHALL have port F_IN, input, 1: response from the unit under check (1 = operand negative).
REQ-012 SHALL have port BUSY, output, 1: high whenever the FSM is not in IDLE.
REQ-013 SHALL have port DONE, output, 1: one-cycle pulse at the end of a completed sweep.
REQ-014 SHALL have port PASS, output, 1: last completed sweep had zero mismatches.
REQ-015 SHALL have port ERR_CNT, output, CNT_W: saturating mismatch count.
REQ-016 SHALL have port FIRST_ERR_A, output, WIDTH: operand of the first mismatch.
REQ-017 SHALL have port FIRST_ERR_VLD, output, 1: FIRST_ERR_A holds a valid value.

Function
REQ-018 FSM states SHALL be IDLE, DRIVE, WAIT, SAMPLE and FIN.
REQ-019 IDLE with START=1: latch FIRST/LAST/SETTLE, set A_OUT=FIRST, clear ERR_CNT and FIRST_ERR_VLD, clear PASS, go to DRIVE.
REQ-020 DRIVE: load the wait counter with the latched SETTLE; go to WAIT if SETTLE>0, else go to SAMPLE.
REQ-021 WAIT: decrement the wait counter each cycle; go to SAMPLE on the cycle the counter reaches 0.
REQ-022 SAMPLE: expected = A_OUT[WIDTH-1]; a mismatch is F_IN != expected.
REQ-023 On a mismatch, ERR_CNT SHALL increment and saturate at 2^CNT_W-1.
REQ-024 On the first mismatch of a sweep, the FSM SHALL capture A_OUT into FIRST_ERR_A and set FIRST_ERR_VLD; later mismatches SHALL NOT overwrite it.
REQ-025 SAMPLE with A_OUT==latched LAST SHALL go to FIN; otherwise A_OUT SHALL become A_OUT+1 modulo 2^WIDTH and the FSM SHALL go to DRIVE.
REQ-026 Per-operand latency SHALL be SETTLE+2 cycles, and A_OUT SHALL remain stable for that whole interval.
REQ-027 FIN: DRIVE DONE=1 for exactly one cycle, set PASS=1 if the final ERR_CNT==0 (the sample taken in that same SAMPLE cycle included), then go to IDLE.
REQ-028 If FIRST>LAST, the sweep SHALL wrap through 2^WIDTH-1 to 0 and cover ((LAST-FIRST) mod 2^WIDTH)+1 operands.
REQ-029 If FIRST==LAST, the sweep SHALL cover exactly one operand.
REQ-030 START while BUSY=1 SHALL be ignored.
REQ-031 ABORT=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with no DONE pulse and PASS=0, leaving ERR_CNT, FIRST_ERR_A and FIRST_ERR_VLD as they are.
REQ-032 ABORT SHALL take priority over every other transition, including SAMPLE to FIN.
REQ-033 In IDLE, A_OUT, ERR_CNT, FIRST_ERR_A, FIRST_ERR_VLD and PASS SHALL hold their values.

Reset
REQ-034 RST_N=0 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE and set A_OUT=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_ERR_A=0, FIRST_ERR_VLD=0 and the wait counter to 0.
REQ-035 Reset asserted mid-sweep SHALL abandon the sweep with no DONE pulse; the first START after RST_N deassertion SHALL begin a clean sweep.

Verification
REQ-036 Correct DUT on F_IN, FIRST=0, LAST=99, SETTLE=0 -> 100 operands in 200 cycles; DONE pulses once; PASS=1, ERR_CNT=0, FIRST_ERR_VLD=0.
REQ-037 F_IN tied to 0, FIRST=0x7E, LAST=0x81, SETTLE=3 -> 20 sweep cycles; ERR_CNT=2, FIRST_ERR_A=0x80, FIRST_ERR_VLD=1, PASS=0.
REQ-038 Wrap sweep, FIRST=0xFE, LAST=0x01, SETTLE=1, correct DUT -> A_OUT sequence FE, FF, 00, 01, each held 3 cycles; PASS=1.
REQ-039 F_IN tied to 1, full sweep 0x00 to 0xFF, CNT_W=4 -> ERR_CNT saturates at 15; FIRST_ERR_A=0x00.
REQ-040 ABORT pulsed during WAIT of operand 5 -> BUSY=0 on the next cycle, no DONE pulse, PASS=0; a START during the sweep is ignored.
REQ-041 RST_N pulsed low mid-sweep between clock edges -> all outputs reach their reset values before the next edge; a new START then runs a full sweep correctly.

Source files
------------

// File: rtl/ltz_sweep_checker.sv
// Sweeps an operand range into a less-than-zero unit and checks each response
// against the operand sign bit, tracking mismatch count and the first failing operand.
module ltz_sweep_checker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  input  logic [3:0]       settle,
  output logic [WIDTH-1:0] a_out,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] first_err_a,
  output logic             first_err_vld
);

  localparam int unsigned SETTLE_W = 4;
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     last_q;
  logic [SETTLE_W-1:0]  settle_q;
  logic [SETTLE_W-1:0]  wait_cnt;

  logic                 mismatch_c;
  logic [CNT_W-1:0]     err_next_c;

  // Expected response is the operand's sign bit; count saturates at all-ones.
  always_comb begin
    mismatch_c = (f_in != a_out[WIDTH-1]);
    err_next_c = err_cnt;
    if (mismatch_c && (err_cnt != ERR_MAX)) begin
      err_next_c = err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_q        <= '0;
      settle_q      <= '0;
      wait_cnt      <= '0;
      a_out         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_a   <= '0;
      first_err_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort overrides every transition and discards the in-flight sample.
      if ((state != IDLE) && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        pass  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              last_q        <= last;
              settle_q      <= settle;
              a_out         <= first;
              err_cnt       <= '0;
              first_err_vld <= 1'b0;
              pass          <= 1'b0;
              busy          <= 1'b1;
              state         <= DRIVE;
            end
          end
          DRIVE: begin
            wait_cnt <= settle_q;
            state    <= (settle_q != '0) ? WAIT : SAMPLE;
          end
          WAIT: begin
            wait_cnt <= wait_cnt - SETTLE_W'(1);
            if (wait_cnt == SETTLE_W'(1)) begin
              state <= SAMPLE;
            end
          end
          SAMPLE: begin
            err_cnt <= err_next_c;
            if (mismatch_c && !first_err_vld) begin
              first_err_a   <= a_out;
              first_err_vld <= 1'b1;
            end
            if (a_out == last_q) begin
              done  <= 1'b1;
              pass  <= (err_next_c == '0);
              state <= FIN;
            end else begin
              a_out <= a_out + WIDTH'(1);
              state <= DRIVE;
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
